// File: rtl/edge_irq_pkg.sv
// edge_irq_pkg: shared types and helpers for the edge-triggered interrupt controller
package edge_irq_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, PRESENT = 1'b1} state_e;
  localparam int MAX_CH = 16;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // Lowest offset from ptr (with wrap) whose pending bit is set wins.
  function automatic int rr_pick(input logic [MAX_CH-1:0] pend, input int ptr, input int n);
    int id;
    int idx;
    id = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n && pend[idx[3:0]]) id = idx;
    end
    return id;
  endfunction
endpackage

// File: rtl/edge_irq_channel.sv
// edge_irq_channel: per-channel synchronizer, debounce, edge detect and pending latch
module edge_irq_channel #(
  parameter int DEB_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             testmode_i,
  input  logic             asyn_i,
  input  logic             en_i,
  input  logic             pos_i,
  input  logic             neg_i,
  input  logic [DEB_W-1:0] deb_limit_i,
  input  logic             ack_i,
  output logic             pending_o,
  output logic             level_o
);
  logic             s1_q, s2_q, stab_q, stab_d, pend_q, pend_d, accept, fire;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  // >= rather than == so a limit lowered below the running count accepts at once
  always_comb begin
    accept = (s2_q != stab_q) && (cnt_q >= deb_limit_i);
    stab_d = testmode_i ? asyn_i : (accept ? s2_q : stab_q);
    cnt_d  = (testmode_i || s2_q == stab_q || accept) ? '0 : cnt_q + 1'b1;
    fire   = en_i & ((stab_d & ~stab_q & pos_i) | (~stab_d & stab_q & neg_i));
    pend_d = en_i & (fire | (pend_q & ~ack_i));
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      stab_q <= 1'b0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      s1_q   <= asyn_i;
      s2_q   <= s1_q;
      stab_q <= stab_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end
  assign pending_o = pend_q;
  assign level_o   = stab_q;
endmodule

// File: rtl/edge_irq_ctrl.sv
// edge_irq_ctrl: N_CH edge-interrupt channels behind a round-robin request/ack arbiter
module edge_irq_ctrl
  import edge_irq_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int DEB_W = 4,
  localparam int ID_W  = id_width(N_CH)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             testmode_i,
  input  logic [N_CH-1:0]  asyn_i,
  input  logic [N_CH-1:0]  cfg_en_i,
  input  logic [N_CH-1:0]  cfg_pos_i,
  input  logic [N_CH-1:0]  cfg_neg_i,
  input  logic [DEB_W-1:0] deb_limit_i,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             irq_ack_i,
  output logic [N_CH-1:0]  pending_o,
  output logic [N_CH-1:0]  level_o
);
  state_e          state_q, state_d;
  logic [ID_W-1:0] id_q, id_d, rr_q, rr_d;
  logic [N_CH-1:0] pending, live, ack_vec;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    edge_irq_channel #(.DEB_W(DEB_W)) u_ch (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .testmode_i (testmode_i),
      .asyn_i     (asyn_i[c]),
      .en_i       (cfg_en_i[c]),
      .pos_i      (cfg_pos_i[c]),
      .neg_i      (cfg_neg_i[c]),
      .deb_limit_i(deb_limit_i),
      .ack_i      (ack_vec[c]),
      .pending_o  (pending[c]),
      .level_o    (level_o[c])
    );
  end
  // Masking with the enable keeps a channel being disabled this cycle from being picked or held.
  always_comb begin
    live    = pending & cfg_en_i;
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    ack_vec = (state_q == PRESENT && irq_ack_i) ? (N_CH'(1) << id_q) : '0;
    if (state_q == IDLE) begin
      if (|live) begin
        state_d = PRESENT;
        id_d    = ID_W'(rr_pick(MAX_CH'(live), int'(rr_q), N_CH));
      end
    end else if (irq_ack_i) begin
      state_d = IDLE;
      rr_d    = (id_q == ID_W'(N_CH - 1)) ? '0 : id_q + 1'b1;
    end else if (!live[id_q]) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end
  assign irq_o     = (state_q == PRESENT);
  assign irq_id_o  = irq_o ? id_q : '0;
  assign pending_o = pending;
endmodule

// File: doc/edge_irq_ctrl.md
# edge_irq_ctrl

Edge-triggered interrupt controller for a bank of asynchronous GPIO/sensor inputs. Per channel it synchronizes the input, debounces it, detects the configured rising and/or falling edges, and latches a pending bit. A round-robin arbiter presents one pending channel at a time to the CPU-side interrupt handshake. It sits between the pad-level inputs and the SoC interrupt fabric.

## Interface
- `N_CH`, 4: number of input channels (2..16).
- `DEB_W`, 4: debounce counter width.
- `ID_W`, $clog2(N_CH): channel ID width (derived, not overridable).

- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `testmode_i` in 1: bypasses synchronizer and debounce; stable value = raw input.
- `asyn_i` in N_CH: asynchronous channel inputs.
- `cfg_en_i` in N_CH: per-channel enable, quasi-static.
- `cfg_pos_i` in N_CH: per-channel rising-edge select.
- `cfg_neg_i` in N_CH: per-channel falling-edge select.
- `deb_limit_i` in DEB_W: debounce length; the new level is accepted after deb_limit_i+1 consecutive differing samples.
- `irq_o` out 1: interrupt request, level.
- `irq_id_o` out ID_W: channel being presented; valid while irq_o=1, otherwise 0.
- `irq_ack_i` in 1: acknowledge, sampled only while irq_o=1.
- `pending_o` out N_CH: pending bits, for status readback.
- `level_o` out N_CH: debounced stable level per channel.

## Operation
- Synchronizer: 2 flops per channel, reset 0.
- Debounce: stable register `stab` and counter `cnt`, both reset 0.
  - sync==stab: cnt<=0.
  - sync!=stab and cnt<deb_limit_i: cnt++.
  - sync!=stab and cnt==deb_limit_i: stab<=sync, cnt<=0.
  - If deb_limit_i is lowered below the current cnt, treat it as cnt>=limit and accept immediately.
- Edge event: asserted in the cycle stab updates.
  - rise = stab goes 0->1; fall = stab goes 1->0.
  - fire = cfg_en_i & ((rise & cfg_pos_i) | (fall & cfg_neg_i)).
- Pending bit:
  - set on fire.
  - cleared on ack of that channel.
  - fire in the same cycle as the ack wins, so the bit stays set.
  - cleared whenever cfg_en_i=0.
- Arbiter FSM, 2 states:
  - IDLE: irq_o=0. If pending!=0, choose the first set bit searching upward from rr_ptr with wrap, latch it into id, go to PRESENT.
  - PRESENT: irq_o=1, irq_id_o=id.
    - irq_ack_i=1: clear pending[id], rr_ptr<=id+1 mod N_CH, go to IDLE.
    - pending[id] drops (channel disabled): go to IDLE, rr_ptr unchanged.
    - Otherwise hold; id never changes while in PRESENT.
- Reset values: irq_o=0, irq_id_o=0, pending_o=0, level_o=0, rr_ptr=0, state IDLE.
- An input already high at reset release produces a rise event, which is pending if enabled with cfg_pos_i=1.
- Reset asserted mid-handshake returns everything to the reset values immediately. Lost events are not recovered.

## Timing
- Input stable from clock edge k with deb_limit_i=L:
  - sync valid at k+1.
  - stab and pending_o update at k+1+L+1 = k+L+2.
  - irq_o rises at k+L+3.
- testmode_i=1: stab follows asyn_i combinationally into the edge compare. pending is set at the first clock edge after the input change.
- Ack to next irq_o: minimum 2 cycles. irq_o is low for exactly 1 cycle (the IDLE cycle) even when more channels are pending.
- A glitch shorter than L+1 sampled cycles produces no event.

## Structure
- Package `edge_irq_pkg` holds:
  - state enum {IDLE, PRESENT}.
  - ID_W computation function.
  - round-robin find-first function (pending, rr_ptr) -> id.
- Sub-module `edge_irq_channel` contains sync, debounce, edge detect and pending for one channel. It is instantiated N_CH times.
- Top level contains the arbiter FSM and rr_ptr.

## Test plan
- Reset with asyn_i[2]=1, cfg_en=4'hF, cfg_pos=4'hF, L=0 -> pending_o=4'b0100 at edge 3 after reset release, irq_o=1 with irq_id_o=2 at edge 4.
- ch0 pulse 0->1->0 of 3 cycles with L=3 -> no event. Same pulse lasting 6 cycles with cfg_pos=1, cfg_neg=1 -> two events (rise then fall), presented as two separate handshakes.
- Channels 0, 1 and 3 pending simultaneously, rr_ptr=0, ack each immediately -> irq_id_o sequence 0, 1, 3, with irq_o low exactly 1 cycle between requests.
- New rise on ch1 in the same cycle as the ack of ch1 -> pending[1] stays 1 and ch1 is presented again after IDLE.
- ch2 presented, cfg_en_i[2] dropped before ack -> irq_o falls next cycle, pending[2]=0, rr_ptr unchanged.
- testmode_i=1, toggle asyn_i[0] with cfg_neg=1 -> pending[0] set at the first edge after the falling transition, no sync or debounce delay.
